// File: rtl/rns789_if.sv
// rns789_if
//   Handshake bundle for the RNS {7,8,9} -> binary reverse converter.
//   master: the side that issues residue triples and consumes results.
//   slave : the converter.
// Signals:
//   in_valid / in_ready : input-side valid/ready
//   r7, r8, r9          : residues mod 7, mod 8, mod 9
//   out_valid/out_ready : output-side valid/ready
//   x, err              : binary result 0..503, illegal-residue flag
interface rns789_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] r7;
  logic [2:0] r8;
  logic [3:0] r9;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] x;
  logic       err;

  modport master (
    output in_valid, r7, r8, r9, out_ready,
    input  in_ready, out_valid, x, err
  );

  modport slave (
    input  in_valid, r7, r8, r9, out_ready,
    output in_ready, out_valid, x, err
  );
endinterface

// File: rtl/rns789_to_binary.sv
// rns789_to_binary
//   Multi-cycle mixed-radix reverse converter, residues {7,8,9} -> X in 0..503.
//   Digit order 8, 7, 9:
//     a1 = r8
//     a2 = (r7 - a1) mod 7          (8^-1 mod 7 = 1)
//     a3 = ((r9 - a1 - 8*a2) * 5) mod 9   (56 mod 9 = 2, 2^-1 mod 9 = 5)
//     x  = a1 + 8*a2 + 56*a3
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rns789_if.slave (in_valid/in_ready, r7/r8/r9, out_valid/out_ready, x, err)
// Build option:
//   RNS789_INVALID_CHECK_EN defined   -> r7=7 or r9>=9 gives err=1, x=0.
//   RNS789_INVALID_CHECK_EN undefined -> err tied 0; r7=7 treated as 0,
//                                        r9 in 9..15 reduced mod 9.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a residue triple
// MR1   | computing digit a2
// MR2   | computing digit a3
// ACC   | accumulating x, registering err
// DONE  | out_valid=1, holding result until out_ready
module rns789_to_binary (
  input  logic     clk,
  input  logic     rst,
  rns789_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, MR1, MR2, ACC, DONE} state_t;

  state_t     state;
  logic [2:0] r7_q;
  logic [3:0] r9_q;
  logic [2:0] a1;
  logic [2:0] a2;
  logic [3:0] a3;
  logic       bad_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic [8:0] x_q;
  logic       err_q;

  logic [2:0] r7_n;
  logic [3:0] r9_n;
  logic       bad_n;
  logic [2:0] a1_m7;
  logic [3:0] d7;
  logic [3:0] d7_red;
  logic [2:0] a2_n;
  logic [5:0] p_lo;
  logic [6:0] d9;
  logic [3:0] m9;
  logic [5:0] t9;
  logic [3:0] a3_n;
  logic [8:0] x_n;

  always_comb begin
    // canonicalise inputs: 7 is the mod-7 double zero, 9..15 wrap into 0..6
    r7_n = (bus.r7 == 3'd7) ? 3'd0 : bus.r7;
    r9_n = (bus.r9 >= 4'd9) ? (bus.r9 - 4'd9) : bus.r9;
`ifdef RNS789_INVALID_CHECK_EN
    bad_n = (bus.r7 == 3'd7) || (bus.r9 >= 4'd9);
`else
    bad_n = 1'b0;
`endif

    // a2: offset by +7 so the difference never goes negative (range 1..13)
    a1_m7  = (a1 == 3'd7) ? 3'd0 : a1;
    d7     = {1'b0, r7_q} + 4'd7 - {1'b0, a1_m7};
    d7_red = (d7 >= 4'd7) ? (d7 - 4'd7) : d7;
    a2_n   = 3'(d7_red);

    // a3: a1 + 8*a2 <= 55, offset by +63 (a multiple of 9) keeps it 8..71
    p_lo = {3'b000, a1} + {a2, 3'b000};
    d9   = {3'b000, r9_q} + 7'd63 - {1'b0, p_lo};
    m9   = 4'(d9 % 7'd9);
    t9   = {2'b00, m9} * 6'd5;
    a3_n = 4'(t9 % 6'd9);

    x_n = {6'd0, a1} + {3'd0, a2, 3'b000} + ({5'd0, a3} * 9'd56);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      err_q       <= 1'b0;
      a1          <= '0;
      a2          <= '0;
      a3          <= '0;
      r7_q        <= '0;
      r9_q        <= '0;
      bad_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            r7_q       <= r7_n;
            r9_q       <= r9_n;
            a1         <= bus.r8;
            bad_q      <= bad_n;
            in_ready_q <= 1'b0;
            state      <= MR1;
          end
        end
        MR1: begin
          a2    <= a2_n;
          state <= MR2;
        end
        MR2: begin
          a3    <= a3_n;
          state <= ACC;
        end
        ACC: begin
          x_q         <= bad_q ? 9'd0 : x_n;
          err_q       <= bad_q;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_rns789_to_binary.sv
// tb_rns789_to_binary
//   Directed and exhaustive checks of the RNS {7,8,9} reverse converter.
//   Inputs are driven and outputs sampled on the falling edge.
module tb_rns789_to_binary;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rns789_if bus ();

  rns789_to_binary dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One conversion. bp: random out_ready stalls in DONE. junk: keep in_valid
  // high with random residues while busy (must be ignored).
  task automatic do_conv(input logic [2:0] v7, input logic [2:0] v8, input logic [3:0] v9,
                         input bit bp, input bit junk,
                         output logic [8:0] xo, output logic eo);
    int n;
    int lat;
    int hold;
    xo = '0;
    eo = 1'b0;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    bus.in_valid  = 1'b1;
    bus.r7        = v7;
    bus.r8        = v8;
    bus.r9        = v9;
    bus.out_ready = bp ? 1'b0 : 1'b1;
    @(negedge clk);
    lat = 1;
    check("busy_in_ready", int'(bus.in_ready), 0);
    if (junk) begin
      bus.r7 = 3'($urandom_range(0, 7));
      bus.r8 = 3'($urandom_range(0, 7));
      bus.r9 = 4'($urandom_range(0, 15));
    end else begin
      bus.in_valid = 1'b0;
    end
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      check("out_valid_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    // edges counted from the accept edge inclusive: accept, MR1, MR2, ACC
    check("latency", lat, 4);
    xo = bus.x;
    eo = bus.err;
    if (bp) begin
      hold = $urandom_range(1, 3);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_x", int'(bus.x), int'(xo));
      end
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("handoff_valid", int'(bus.out_valid), 0);
    check("handoff_ready", int'(bus.in_ready), 1);
  endtask

  logic [8:0] xr;
  logic       er;
  int         q[$];
  int         vals[4];
  int         idx;
  int         last;
  int         cyc;
  int         n;

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.r7        = '0;
    bus.r8        = '0;
    bus.r9        = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_x", int'(bus.x), 0);
    check("rst_err", int'(bus.err), 0);
    rst = 1'b0;

    do_conv(3'd2, 3'd4, 4'd1, 1'b0, 1'b0, xr, er);
    check("x_100", int'(xr), 100);
    check("err_100", int'(er), 0);
    do_conv(3'd6, 3'd7, 4'd8, 1'b0, 1'b0, xr, er);
    check("x_503", int'(xr), 503);
    do_conv(3'd0, 3'd0, 4'd0, 1'b0, 1'b0, xr, er);
    check("x_0", int'(xr), 0);
    do_conv(3'd1, 3'd1, 4'd3, 1'b0, 1'b0, xr, er);
    check("x_57", int'(xr), 57);

    for (int v = 0; v < 504; v++) begin
      do_conv(3'(v % 7), 3'(v % 8), 4'(v % 9), 1'b1, 1'b1, xr, er);
      check("exh_x", int'(xr), v);
      check("exh_err", int'(er), 0);
    end

    do_conv(3'd7, 3'd0, 4'd0, 1'b0, 1'b0, xr, er);
`ifdef RNS789_INVALID_CHECK_EN
    check("ill_r7_x", int'(xr), 0);
    check("ill_r7_err", int'(er), 1);
`else
    check("ill_r7_x", int'(xr), 0);
    check("ill_r7_err", int'(er), 0);
`endif
    do_conv(3'd0, 3'd0, 4'd12, 1'b0, 1'b0, xr, er);
`ifdef RNS789_INVALID_CHECK_EN
    check("ill_r9_x", int'(xr), 0);
    check("ill_r9_err", int'(er), 1);
`else
    check("ill_r9_x", int'(xr), 336);
    check("ill_r9_err", int'(er), 0);
`endif

    // back-to-back with in_valid held high
    vals[0] = 0; vals[1] = 57; vals[2] = 503; vals[3] = 100;
    bus.out_ready = 1'b1;
    idx  = 0;
    last = -1;
    cyc  = 0;
    while (cyc < 80 && (idx < 4 || q.size() > 0)) begin
      @(negedge clk);
      cyc++;
      if (idx == 4 && !bus.in_ready) bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        if (q.size() > 0) check("stream_x", int'(bus.x), q.pop_front());
        else check("stream_extra", 1, 0);
      end
      if (bus.in_ready && idx < 4) begin
        if (last >= 0) check("stream_interval", cyc - last, 5);
        last = cyc;
        bus.in_valid = 1'b1;
        bus.r7 = 3'(vals[idx] % 7);
        bus.r8 = 3'(vals[idx] % 8);
        bus.r9 = 4'(vals[idx] % 9);
        q.push_back(vals[idx]);
        idx++;
      end
    end
    bus.in_valid = 1'b0;
    check("stream_drain", q.size(), 0);
    check("stream_count", idx, 4);

    // reset during MR2 (x currently holds 100)
    @(negedge clk);
    bus.r7 = 3'd1; bus.r8 = 3'd1; bus.r9 = 4'd3;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mr2_valid", int'(bus.out_valid), 0);
    check("rst_mr2_ready", int'(bus.in_ready), 1);
    check("rst_mr2_x", int'(bus.x), 0);
    rst = 1'b0;
    do_conv(3'd1, 3'd1, 4'd3, 1'b0, 1'b0, xr, er);
    check("post_rst_mr2_x", int'(xr), 57);

    // reset during a stalled DONE
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.r7 = 3'd2; bus.r8 = 3'd4; bus.r9 = 4'd1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_done_valid", int'(bus.out_valid), 1);
    check("stall_done_x", int'(bus.x), 100);
    repeat (3) @(negedge clk);
    check("stall_done_hold", int'(bus.x), 100);
    rst = 1'b1;
    @(negedge clk);
    check("rst_done_valid", int'(bus.out_valid), 0);
    check("rst_done_ready", int'(bus.in_ready), 1);
    check("rst_done_x", int'(bus.x), 0);
    rst = 1'b0;
    do_conv(3'd1, 3'd1, 4'd3, 1'b0, 1'b0, xr, er);
    check("post_rst_done_x", int'(xr), 57);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
